// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Collects a stream of N_BITS-wide UART bytes, assembles them big-endian into
//   NB_DATA-wide words and writes each word to program memory at addresses
//   advancing by ADDR_STEP. A load ends when the programmable END_WORD has been
//   written, or when the next address would leave the address space (overflow).
//   finish_rcv_o then stays high until clear_i re-arms the loader.
//
//   Optional feature (macro UART_MEM_LOADER_CHECKSUM_EN):
//     A running XOR of every accepted byte is kept. After END_WORD the loader
//     waits for one more byte and compares it with that XOR. A mismatch raises
//     checksum_err_o. Without the macro checksum_err_o is tied to 0.
//
//   Ports
//     clock          system clock
//     reset          asynchronous, active-low reset
//     rx_done_tick_i one-cycle strobe, rx_data_i valid
//     rx_data_i      received byte
//     clear_i        synchronous re-arm: back to IDLE, address/count/flags 0
//     mem_wr_o       one-cycle memory write strobe
//     mem_addr_o     write address (registered, held between writes)
//     mem_data_o     write data    (registered, held between writes)
//     word_count_o   words written since arm
//     finish_rcv_o   level, load complete
//     overflow_o     level, address space exhausted before END_WORD
//     checksum_err_o level, checksum byte mismatch (optional feature)
//
//   NB_DATA must be an integer multiple of N_BITS.

module uart_mem_loader #(
    parameter int                 N_BITS    = 8,
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 7,
    parameter int                 ADDR_STEP = 4,
    parameter logic [NB_DATA-1:0] END_WORD  = 32'hFFFF_FFFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_done_tick_i,
    input  logic [N_BITS-1:0]  rx_data_i,
    input  logic               clear_i,
    output logic               mem_wr_o,
    output logic [NB_ADDR-1:0] mem_addr_o,
    output logic [NB_DATA-1:0] mem_data_o,
    output logic [NB_ADDR:0]   word_count_o,
    output logic               finish_rcv_o,
    output logic               overflow_o,
    output logic               checksum_err_o
);

    localparam int BPW   = NB_DATA / N_BITS;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [NB_ADDR-1:0] STEP_A    = NB_ADDR'(ADDR_STEP);
    localparam logic [NB_ADDR:0]   STEP_W    = (NB_ADDR + 1)'(ADDR_STEP);
    localparam logic [NB_ADDR:0]   ADDR_MAX  = {1'b0, {NB_ADDR{1'b1}}};
    localparam logic [NB_ADDR:0]   COUNT_ONE = (NB_ADDR + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    byte_cnt;
    logic [NB_DATA-1:0]  shift_reg;
    logic [NB_DATA-1:0]  shift_next;
    logic [NB_ADDR-1:0]  addr;
    logic [NB_ADDR:0]    addr_sum;
    logic                take_byte;
    logic                is_end;
    logic                addr_over;
    logic                overflow_q;

    // Word being written is in mem_data_o/mem_addr_o during WRITE, so the
    // end and overflow decisions are made from those registers.
    assign shift_next = (shift_reg << N_BITS) | NB_DATA'(rx_data_i);
    assign is_end     = (mem_data_o == END_WORD);
    assign addr_sum   = {1'b0, mem_addr_o} + STEP_W;
    assign addr_over  = (addr_sum > ADDR_MAX);

    assign mem_wr_o     = (state == ST_WRITE);
    assign finish_rcv_o = (state == ST_DONE);
    assign overflow_o   = overflow_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of process order.
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and byte acceptance
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // variable unassigned and infers a latch.
        state_next = state;
        take_byte  = 1'b0;

        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (rx_done_tick_i) begin
                    take_byte  = 1'b1;
                    state_next = (byte_cnt == LAST_BYTE) ? ST_WRITE : ST_COLLECT;
                end
            end

            ST_WRITE: begin
                if (is_end) begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
`endif
                end else if (addr_over) begin
                    state_next = ST_DONE;
                end else begin
                    // A tick during the write cycle already belongs to the
                    // next word; byte_cnt is 0 here so it becomes byte 0.
                    state_next = ST_COLLECT;
                    if (rx_done_tick_i) begin
                        take_byte  = 1'b1;
                        state_next = (byte_cnt == LAST_BYTE) ? ST_WRITE : ST_COLLECT;
                    end
                end
            end

`ifdef UART_MEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_done_tick_i) begin
                    state_next = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                state_next = ST_DONE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Re-arm overrides everything, including a byte on the same cycle.
        if (clear_i) begin
            state_next = ST_IDLE;
            take_byte  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: byte assembly, write registers, address and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_cnt     <= '0;
            shift_reg    <= '0;
            addr         <= '0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            word_count_o <= '0;
            overflow_q   <= 1'b0;
        end else if (clear_i) begin
            // mem_addr_o/mem_data_o keep their last values; byte_cnt=0 is
            // enough to discard any partial word left in shift_reg.
            byte_cnt     <= '0;
            addr         <= '0;
            word_count_o <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (take_byte) begin
                shift_reg <= shift_next;
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt   <= '0;
                    mem_data_o <= shift_next;
                    // With one byte per word the next write can follow a
                    // write directly, before addr has been advanced.
                    mem_addr_o <= (state == ST_WRITE) ? addr + STEP_A : addr;
                end else begin
                    byte_cnt <= byte_cnt + CNT_ONE;
                end
            end

            if (state == ST_WRITE) begin
                addr         <= addr + STEP_A;
                word_count_o <= word_count_o + COUNT_ONE;
                if (!is_end && addr_over) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running XOR checksum of accepted bytes and the final comparison
    // ------------------------------------------------------------------
    logic [N_BITS-1:0] xor_acc;
    logic              checksum_err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xor_acc        <= '0;
            checksum_err_q <= 1'b0;
        end else if (clear_i) begin
            xor_acc        <= '0;
            checksum_err_q <= 1'b0;
        end else begin
            if (take_byte) begin
                xor_acc <= xor_acc ^ rx_data_i;
            end
            if (state == ST_CHECK && rx_done_tick_i) begin
                checksum_err_q <= (rx_data_i != xor_acc);
            end
        end
    end

    assign checksum_err_o = checksum_err_q;
`else
    assign checksum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader
//   Directed bench for uart_mem_loader with default parameters
//   (8-bit bytes, 32-bit words, 7-bit address, step 4, end word FFFF_FFFF).
//   Inputs change just after the falling edge; outputs are checked 1 time
//   unit after the falling edge. A monitor logs every write strobe.

module tb_uart_mem_loader;

    logic        clock;
    logic        reset;
    logic        rx_done_tick_i;
    logic [7:0]  rx_data_i;
    logic        clear_i;
    logic        mem_wr_o;
    logic [6:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic [7:0]  word_count_o;
    logic        finish_rcv_o;
    logic        overflow_o;
    logic        checksum_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    uart_mem_loader dut (
        .clock          (clock),
        .reset          (reset),
        .rx_done_tick_i (rx_done_tick_i),
        .rx_data_i      (rx_data_i),
        .clear_i        (clear_i),
        .mem_wr_o       (mem_wr_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .word_count_o   (word_count_o),
        .finish_rcv_o   (finish_rcv_o),
        .overflow_o     (overflow_o),
        .checksum_err_o (checksum_err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_wr_o) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_data_o);
        end
    end

    typedef struct {
        logic [31:0] word;
        logic [6:0]  addr;
        logic [7:0]  count;
        logic        fin;
    } vec_t;

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    localparam logic FIN_AT_END = 1'b0;
`else
    localparam logic FIN_AT_END = 1'b1;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; returns 1 unit after the next falling edge.
    task automatic cyc(input logic t, input logic [7:0] d, input logic c);
        rx_done_tick_i = t;
        rx_data_i      = d;
        clear_i        = c;
        @(negedge clock);
        #1;
    endtask

    // Sends a word big-endian with 'gap' idle cycles between bytes; returns
    // in the cycle right after the last byte's tick.
    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, w[31 - 8*i -: 8], 1'b0);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) cyc(1'b0, 8'h00, 1'b0);
            end
        end
    endtask

    task automatic expect_write(input string name, input int idx,
                                input logic [6:0] a, input logic [31:0] d);
        n_checks++;
        if (wr_addr_q.size() <= idx) begin
            n_fail++;
            $display("FAIL %s: write %0d missing, only %0d writes seen", name, idx, wr_addr_q.size());
        end else if (wr_addr_q[idx] !== a || wr_data_q[idx] !== d) begin
            n_fail++;
            $display("FAIL %s: got addr %0h data %0h, expected addr %0h data %0h",
                     name, wr_addr_q[idx], wr_data_q[idx], a, d);
        end
    endtask

    initial begin
        vec_t tbl[4];
        int   base;

        tbl[0] = '{word: 32'h1234_5678, addr: 7'd0,  count: 8'd1, fin: 1'b0};
        tbl[1] = '{word: 32'h00C0_FFEE, addr: 7'd4,  count: 8'd2, fin: 1'b0};
        tbl[2] = '{word: 32'hA5A5_A5A5, addr: 7'd8,  count: 8'd3, fin: 1'b0};
        tbl[3] = '{word: 32'hFFFF_FFFF, addr: 7'd12, count: 8'd4, fin: FIN_AT_END};

        rx_done_tick_i = 1'b0;
        rx_data_i      = 8'h00;
        clear_i        = 1'b0;
        reset          = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clock);
        #1;
        check("reset mem_wr",       64'(mem_wr_o),       64'd0);
        check("reset mem_addr",     64'(mem_addr_o),     64'd0);
        check("reset mem_data",     64'(mem_data_o),     64'd0);
        check("reset word_count",   64'(word_count_o),   64'd0);
        check("reset finish",       64'(finish_rcv_o),   64'd0);
        check("reset overflow",     64'(overflow_o),     64'd0);
        check("reset checksum_err", 64'(checksum_err_o), 64'd0);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);

        // ---------------- program load, table driven ----------------
        for (int v = 0; v < 4; v++) begin
            send_word(tbl[v].word, 1);
            check($sformatf("load%0d wr strobe", v), 64'(mem_wr_o),   64'd1);
            check($sformatf("load%0d addr", v),      64'(mem_addr_o), 64'(tbl[v].addr));
            check($sformatf("load%0d data", v),      64'(mem_data_o), 64'(tbl[v].word));
            cyc(1'b0, 8'h00, 1'b0);
            check($sformatf("load%0d strobe end", v), 64'(mem_wr_o),     64'd0);
            check($sformatf("load%0d count", v),      64'(word_count_o), 64'(tbl[v].count));
            check($sformatf("load%0d finish", v),     64'(finish_rcv_o), 64'(tbl[v].fin));
        end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        // XOR of all 16 load bytes is 0xD9.
        cyc(1'b1, 8'hD9, 1'b0);
        check("load checksum finish", 64'(finish_rcv_o),   64'd1);
        check("load checksum err",    64'(checksum_err_o), 64'd0);
`endif
        base = wr_addr_q.size();
        send_word(32'h0BAD_0BAD, 0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        check("done ignores bytes", 64'(wr_addr_q.size()), 64'(base));
        check("done count held",    64'(word_count_o),     64'd4);
        check("done finish held",   64'(finish_rcv_o),     64'd1);
        check("load no overflow",   64'(overflow_o),       64'd0);

        // ---------------- clear, then back-to-back words ----------------
        cyc(1'b0, 8'h00, 1'b1);
        check("clear finish", 64'(finish_rcv_o), 64'd0);
        check("clear count",  64'(word_count_o), 64'd0);
        base = wr_addr_q.size();
        send_word(32'h1122_3344, 0);
        send_word(32'h5566_7788, 0);   // first tick lands in the write cycle
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        expect_write("b2b word1", base,     7'd0, 32'h1122_3344);
        expect_write("b2b word2", base + 1, 7'd4, 32'h5566_7788);
        check("b2b count", 64'(word_count_o), 64'd2);

        // ---------------- clear after partial word, byte on clear dropped ----
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        cyc(1'b1, 8'h99, 1'b1);
        base = wr_addr_q.size();
        send_word(32'hAABB_CCDD, 0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        check("partial clear writes", 64'(wr_addr_q.size() - base), 64'd1);
        expect_write("partial clear word", base, 7'd0, 32'hAABB_CCDD);

        // ---------------- clear during the write cycle ----------------
        base = wr_addr_q.size();
        send_word(32'h600D_F00D, 0);
        cyc(1'b0, 8'h00, 1'b1);
        expect_write("clear in write strobe", base, 7'd4, 32'h600D_F00D);
        check("clear in write count", 64'(word_count_o), 64'd0);
        send_word(32'h7777_1111, 0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_write("after clear addr0", base + 1, 7'd0, 32'h7777_1111);

        // ---------------- overflow ----------------
        cyc(1'b0, 8'h00, 1'b1);
        base = wr_addr_q.size();
        for (int i = 0; i < 32; i++) begin
            send_word(32'h0100_0000 | 32'(i), 0);
            if (i == 30) check("pre-overflow flag", 64'(overflow_o), 64'd0);
        end
        cyc(1'b0, 8'h00, 1'b0);
        check("overflow writes",   64'(wr_addr_q.size() - base), 64'd32);
        expect_write("overflow last", base + 31, 7'd124, 32'h0100_001F);
        check("overflow flag",     64'(overflow_o),   64'd1);
        check("overflow finish",   64'(finish_rcv_o), 64'd1);
        check("overflow count",    64'(word_count_o), 64'd32);
        send_word(32'h2222_2222, 0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        check("no wrap write", 64'(wr_addr_q.size() - base), 64'd32);

        // ---------------- asynchronous reset mid-word ----------------
        cyc(1'b0, 8'h00, 1'b1);
        send_word(32'h1357_9BDF, 1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0);
        rx_done_tick_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async rst data",   64'(mem_data_o),   64'd0);
        check("async rst addr",   64'(mem_addr_o),   64'd0);
        check("async rst count",  64'(word_count_o), 64'd0);
        check("async rst finish", 64'(finish_rcv_o), 64'd0);
        check("async rst wr",     64'(mem_wr_o),     64'd0);
        @(negedge clock);
        #1 reset = 1'b1;
        base = wr_addr_q.size();
        send_word(32'hDEAD_BEEF, 0);
        cyc(1'b0, 8'h00, 1'b0);
        expect_write("post reset word", base, 7'd0, 32'hDEAD_BEEF);

`ifdef UART_MEM_LOADER_CHECKSUM_EN
        // ---------------- checksum byte, good and bad ----------------
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            send_word(32'h0102_0304, 1);
            cyc(1'b0, 8'h00, 1'b0);
            send_word(32'hFFFF_FFFF, 1);
            cyc(1'b0, 8'h00, 1'b0);
            check($sformatf("cks%0d wait finish", k), 64'(finish_rcv_o), 64'd0);
            cyc(1'b1, (k == 0) ? 8'h04 : 8'h05, 1'b0);
            check($sformatf("cks%0d finish", k), 64'(finish_rcv_o),   64'd1);
            check($sformatf("cks%0d err", k),    64'(checksum_err_o), 64'(k));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
